// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and helpers for the 8-way round-robin mux arbiter.
//   N_REQ        number of requesters sharing the 8:1 datapath mux
//   SEL_W        width of the mux select {s2,s1,s0}
//   arb_state_t  arbiter FSM state
//   onehot8()    select index -> one-hot grant vector
package cpu_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Handshake/bus bundle between the arbiter, its requesters and the consumer.
//   req          per-requester request (bit i -> mux input i)
//   gnt          one-hot grant, zero when idle
//   s2/s1/s0     mux select = index of the granted requester
//   out_valid    mux output carries granted data
//   out_ready    consumer accepts this cycle
//   timeout_err  one-cycle pulse on grant revocation by timeout
//   lock         burst hold, only with MUX8_ARB_LOCK_EN defined
// Modports: master = arbiter side, slave = requesters/consumer side.
interface mux8_rr_arbiter_if;
  import cpu_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             s2;
  logic             s1;
  logic             s0;
  logic             out_valid;
  logic             out_ready;
  logic             timeout_err;
`ifdef MUX8_ARB_LOCK_EN
  logic             lock;

  modport master (
    input  req, out_ready, lock,
    output gnt, s2, s1, s0, out_valid, timeout_err
  );
  modport slave (
    output req, out_ready, lock,
    input  gnt, s2, s1, s0, out_valid, timeout_err
  );
`else
  modport master (
    input  req, out_ready,
    output gnt, s2, s1, s0, out_valid, timeout_err
  );
  modport slave (
    output req, out_ready,
    input  gnt, s2, s1, s0, out_valid, timeout_err
  );
`endif

endinterface

// File: rtl/mux8_rr_arbiter_pick.sv
// rr_pick8: combinational rotating priority encoder.
// Finds the first set bit of req at or after ptr, wrapping 7 -> 0.
//   req  request vector
//   ptr  starting index of the search
//   any  at least one request set
//   idx  index of the winning request (don't-care when any = 0)
module rr_pick8
  import cpu_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  // rot[k] == req[(ptr + k) mod 8]: rotating lets a plain lowest-bit
  // search implement the wrap-around priority.
  assign dbl = {req, req};
  assign rot = dbl[ptr +: N_REQ];

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign any = |rot;
  assign idx = ptr + off;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing the 32-bit 8:1 datapath mux among 8 requesters.
// Drives the mux select, a one-hot grant and a valid/ready handshake to the
// downstream consumer; a grant timeout keeps a stalled consumer from hanging
// the datapath.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mux8_rr_arbiter_if.master (req, gnt, s2/s1/s0, out_valid,
//          out_ready, timeout_err, and lock when enabled)
// Parameter:
//   TIMEOUT  grant cycles without out_ready before revocation (0 = never)
// Build option:
//   MUX8_ARB_LOCK_EN  adds the lock input; lock on an accept keeps the grant
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant; searching req from ptr
// GRANT | gnt/sel drive the mux, out_valid=1, waiting for out_ready
module mux8_rr_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst_n,
  mux8_rr_arbiter_if.master bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic TIMEOUT_ON = (TIMEOUT != 0);

  arb_state_t       state;
  logic [N_REQ-1:0] gnt_q;
  logic [SEL_W-1:0] sel_q;
  logic             valid_q;
  logic             err_q;
  logic [SEL_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             win_req;
  logic             lock_hold;
  logic             timeout_hit;
  logic [N_REQ-1:0] pick_req;
  logic [SEL_W-1:0] pick_ptr;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;

  assign accept      = valid_q & bus.out_ready;
  assign win_req     = bus.req[sel_q];
  assign timeout_hit = TIMEOUT_ON && (cnt_q == CNT_LAST);

`ifdef MUX8_ARB_LOCK_EN
  // A lock without the winner's request is just a normal accept.
  assign lock_hold = bus.lock & win_req;
`else
  assign lock_hold = 1'b0;
`endif

  // One picker serves both cases: in IDLE it searches from ptr; on an accept
  // it searches from winner+1 (the ptr value being written this edge) with
  // the current winner masked so it cannot win twice in a row.
  assign pick_req = (state == GRANT) ? (bus.req & ~gnt_q) : bus.req;
  assign pick_ptr = (state == GRANT) ? (sel_q + 3'd1) : ptr_q;

  rr_pick8 u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state   <= GRANT;
            gnt_q   <= onehot8(pick_idx);
            sel_q   <= pick_idx;
            valid_q <= 1'b1;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (accept) begin
            if (lock_hold) begin
              cnt_q <= '0;
            end else begin
              ptr_q <= sel_q + 3'd1;
              if (pick_any) begin
                gnt_q <= onehot8(pick_idx);
                sel_q <= pick_idx;
                cnt_q <= '0;
              end else begin
                // sel keeps its last value so the mux output stays quiet.
                state   <= IDLE;
                gnt_q   <= '0;
                valid_q <= 1'b0;
              end
            end
          end else if (!win_req) begin
            state   <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= sel_q + 3'd1;
          end else if (timeout_hit) begin
            state   <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= sel_q + 3'd1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          gnt_q   <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt                    = gnt_q;
  assign {bus.s2, bus.s1, bus.s0}   = sel_q;
  assign bus.out_valid              = valid_q;
  assign bus.timeout_err            = err_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter (TIMEOUT = 4).
// Stimulus pushes the expected grant of every accept (and 0 for every
// timeout pulse) into a queue; a monitor pops and compares on each
// out_valid&out_ready cycle or timeout_err pulse. Directed checks cover
// latency, pointer position, timeout boundary and async reset.
module tb_mux8_rr_arbiter;
  import cpu_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] exp_q[$];

  mux8_rr_arbiter_if bus ();

  mux8_rr_arbiter #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] idx_of(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] g);
    exp_q.push_back(g);
  endtask

  // Monitor: scoreboard compare plus output invariants.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      check("inv_valid_eq_or_gnt", {31'd0, bus.out_valid}, {31'd0, |bus.gnt});
      check("inv_gnt_onehot0", {31'd0, $onehot0(bus.gnt)}, 32'd1);
      if ((bus.out_valid && bus.out_ready) || bus.timeout_err) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: gnt=%0h err=%0b with empty queue at %0t",
                   bus.gnt, bus.timeout_err, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_gnt", {24'd0, bus.gnt}, {24'd0, e});
          if (e != 8'h00)
            check("sb_sel", {29'd0, bus.s2, bus.s1, bus.s0}, {29'd0, idx_of(e)});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] oh;
    rst_n         = 1'b1;
    bus.req       = 8'h00;
    bus.out_ready = 1'b0;
`ifdef MUX8_ARB_LOCK_EN
    bus.lock      = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #2;
    check("rst_gnt", {24'd0, bus.gnt}, 32'd0);
    check("rst_sel", {29'd0, bus.s2, bus.s1, bus.s0}, 32'd0);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_err", {31'd0, bus.timeout_err}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Round robin, all requesting, consumer always ready.
    bus.req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      oh = 8'h01 << (k % 8);
      check("rr_valid", {31'd0, bus.out_valid}, 32'd1);
      check("rr_gnt", {24'd0, bus.gnt}, {24'd0, oh});
      push(oh);
      bus.out_ready = 1'b1;
      tick();
      bus.req = 8'hFF & ~oh;
    end
    bus.req       = 8'h00;
    bus.out_ready = 1'b0;
    check("rr_after_gnt", {24'd0, bus.gnt}, 32'h02);
    tick();
    check("withdraw_gnt", {24'd0, bus.gnt}, 32'd0);
    check("withdraw_err", {31'd0, bus.timeout_err}, 32'd0);

    // Single request.
    bus.req = 8'h08;
    tick();
    check("single_gnt", {24'd0, bus.gnt}, 32'h08);
    check("single_sel", {29'd0, bus.s2, bus.s1, bus.s0}, 32'd3);
    check("single_valid", {31'd0, bus.out_valid}, 32'd1);
    push(8'h08);
    bus.out_ready = 1'b1;
    tick();
    bus.req       = 8'h00;
    bus.out_ready = 1'b0;
    check("single_idle_gnt", {24'd0, bus.gnt}, 32'd0);
    check("single_idle_valid", {31'd0, bus.out_valid}, 32'd0);
    check("single_sel_hold", {29'd0, bus.s2, bus.s1, bus.s0}, 32'd3);

    // ptr now 4: of {3,4} requester 4 wins, then 3 back-to-back.
    bus.req = 8'h18;
    tick();
    check("ptr4_gnt", {24'd0, bus.gnt}, 32'h10);
    push(8'h10);
    bus.out_ready = 1'b1;
    tick();
    bus.req = 8'h08;
    check("b2b_gnt", {24'd0, bus.gnt}, 32'h08);
    check("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
    push(8'h08);
    tick();
    bus.req       = 8'h00;
    bus.out_ready = 1'b0;
    check("b2b_idle_valid", {31'd0, bus.out_valid}, 32'd0);

    // Move ptr to 6 via requester 5.
    bus.req = 8'h20;
    tick();
    push(8'h20);
    bus.out_ready = 1'b1;
    tick();
    bus.req       = 8'h00;
    bus.out_ready = 1'b0;

    // Wrap: ptr=6, req=0x21 -> 0 then 5.
    bus.req = 8'h21;
    tick();
    check("wrap_gnt0", {24'd0, bus.gnt}, 32'h01);
    push(8'h01);
    bus.out_ready = 1'b1;
    tick();
    bus.req = 8'h20;
    check("wrap_gnt5", {24'd0, bus.gnt}, 32'h20);
    push(8'h20);
    tick();
    bus.req       = 8'h00;
    bus.out_ready = 1'b0;
    check("wrap_idle_gnt", {24'd0, bus.gnt}, 32'd0);

    // Timeout: 4 grant cycles without ready, then a one-cycle error.
    bus.req = 8'h02;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("to_gnt_held", {24'd0, bus.gnt}, 32'h02);
      check("to_no_err", {31'd0, bus.timeout_err}, 32'd0);
      if (i == 3) push(8'h00);
      tick();
    end
    bus.req = 8'h00;
    check("to_err_pulse", {31'd0, bus.timeout_err}, 32'd1);
    check("to_gnt_revoked", {24'd0, bus.gnt}, 32'd0);
    check("to_valid_low", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("to_err_one_cycle", {31'd0, bus.timeout_err}, 32'd0);

    // ptr=2 after timeout; accept on the last allowed cycle wins.
    bus.req = 8'h06;
    tick();
    check("to_ptr2_gnt", {24'd0, bus.gnt}, 32'h04);
    for (int i = 0; i < 3; i++) begin
      check("tov_gnt_held", {24'd0, bus.gnt}, 32'h04);
      tick();
    end
    push(8'h04);
    bus.out_ready = 1'b1;
    tick();
    bus.req       = 8'h02;
    bus.out_ready = 1'b0;
    check("tov_no_err", {31'd0, bus.timeout_err}, 32'd0);
    check("tov_next_gnt", {24'd0, bus.gnt}, 32'h02);
    bus.req = 8'h00;
    tick();
    check("tov_withdraw_gnt", {24'd0, bus.gnt}, 32'd0);
    check("tov_withdraw_err", {31'd0, bus.timeout_err}, 32'd0);

    // Async reset in the middle of a grant.
    bus.req = 8'h10;
    tick();
    check("ar_gnt", {24'd0, bus.gnt}, 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check("ar_gnt_clr", {24'd0, bus.gnt}, 32'd0);
    check("ar_sel_clr", {29'd0, bus.s2, bus.s1, bus.s0}, 32'd0);
    check("ar_valid_clr", {31'd0, bus.out_valid}, 32'd0);
    bus.req = 8'h00;
    tick();
    rst_n = 1'b1;
    bus.req = 8'h81;
    tick();
    check("ar_ptr0_gnt", {24'd0, bus.gnt}, 32'h01);
    push(8'h01);
    bus.out_ready = 1'b1;
    tick();
    bus.req = 8'h80;
    check("ar_next_gnt", {24'd0, bus.gnt}, 32'h80);
    push(8'h80);
    tick();
    bus.req       = 8'h00;
    bus.out_ready = 1'b0;

`ifdef MUX8_ARB_LOCK_EN
    // Lock: requester 0 keeps the grant over three locked accepts.
    bus.req = 8'h03;
    tick();
    bus.lock      = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("lock_gnt_held", {24'd0, bus.gnt}, 32'h01);
      push(8'h01);
      tick();
    end
    bus.lock = 1'b0;
    check("lock_gnt_4th", {24'd0, bus.gnt}, 32'h01);
    push(8'h01);
    tick();
    bus.req = 8'h02;
    check("lock_release_gnt", {24'd0, bus.gnt}, 32'h02);
    push(8'h02);
    tick();
    bus.req       = 8'h00;
    bus.out_ready = 1'b0;
`endif

    tick();
    tick();
    check("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares the 32-bit 8:1 datapath mux (mux8_to_1) among 8 requesters.
- Drives the mux select lines s2/s1/s0 and a one-hot grant vector.
- Presents a valid/ready handshake to the downstream consumer, typically a register-file write port or bus driver.
- Includes a grant timeout so a stalled consumer cannot hang the datapath.

Parameters:
- TIMEOUT, 16: GRANT cycles without out_ready before the grant is revoked. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  8  request per requester; bit i requests mux input i (0=a ... 7=h)
- gnt  out  8  one-hot registered grant; all zero when idle
- s2  out  1  mux select MSB
- s1  out  1  mux select bit 1
- s0  out  1  mux select LSB; {s2,s1,s0} = index of the granted requester
- out_valid  out  1  mux output holds a granted requester's data
- out_ready  in  1  consumer accepts the data this cycle
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout
- lock  in  1  burst hold; present only with MUX8_ARB_LOCK_EN

Behaviour:
- Reset (async on rst_n low): state=IDLE, gnt=0, {s2,s1,s0}=000, out_valid=0, timeout_err=0, ptr=0, cnt=0.
- State IDLE:
  - If req!=0, pick the first set bit at or after ptr, wrapping 7->0.
  - Next cycle: state=GRANT, gnt=onehot(winner), sel=winner, out_valid=1, cnt=0.
  - Latency req->gnt is exactly 1 cycle.
- State GRANT, accept (out_valid & out_ready):
  - Transfer completes; ptr <= (winner+1) mod 8.
  - Re-arbitrate the same cycle over req & ~gnt, from the new ptr.
  - If any bit is set: stay in GRANT with the new winner next cycle, cnt=0. This gives zero-bubble back-to-back transfers.
  - Otherwise: go to IDLE; gnt=0, out_valid=0, sel holds its last value.
- Requester rule: the requester drops req in the cycle after gnt[i]&out_ready. The arbiter masks it during the accept cycle, so it cannot win twice in a row without the lock feature.
- Withdraw: if req[winner]=0 in GRANT without accept, the grant is cancelled. Next state is IDLE, ptr <= winner+1, timeout_err stays 0.
- Timeout:
  - cnt increments on each GRANT cycle without accept.
  - If TIMEOUT!=0 and cnt==TIMEOUT-1 with no accept: revoke the grant, pulse timeout_err for 1 cycle, ptr <= winner+1, go to IDLE.
  - An accept in the same cycle as cnt==TIMEOUT-1 wins: no error.
- Simultaneous requests: strict rotation. Each requester waits at most 7 grants (bounded starvation).
- sel changes only on clock edges where gnt changes, so the mux output is glitch-free relative to out_valid.
- Invariants: out_valid == |gnt; gnt is always one-hot or zero.
- Reset mid-transfer: all outputs return to reset values immediately. The in-flight transfer is lost and requesters must re-request.

Optional Feature:
- MUX8_ARB_LOCK_EN defined:
  - The lock port exists.
  - If lock=1 on an accept, the winner keeps its grant. There is no re-arbitration, ptr is unchanged and cnt=0.
  - The winner must keep req high.
  - A lock=1 with req[winner]=0 is treated as a normal accept.
- MUX8_ARB_LOCK_EN undefined: no lock port; every accept re-arbitrates.

Decomposition:
- Package cpu_arb_pkg:
  - N_REQ=8, SEL_W=3.
  - arb_state_t enum {IDLE, GRANT}.
  - Function onehot8(idx).
- Sub-module rr_pick8: combinational rotating priority encoder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0].
- Top holds the FSM, ptr, cnt and the output registers.

Test Plan:
- Single request: req=0x08 from IDLE -> 1 cycle later gnt=0x08, sel=011, out_valid=1. out_ready=1 -> next cycle gnt=0, out_valid=0, ptr=4.
- Round-robin with out_ready=1 continuous: req=0xFF held (each bit drops only after its own accept, then re-raises) -> grant order 0,1,2,...,7,0 with no idle cycles between grants.
- Pointer wrap: ptr=6, req=0x21 -> winner 0 (7->0 wrap skips 5 until after 0); next winner 5.
- Timeout: TIMEOUT=4, req=0x02, out_ready=0 -> gnt=0x02 for 4 cycles, then timeout_err=1 for one cycle, gnt=0, ptr=2. Variant with out_ready=1 on the 4th cycle -> no error.
- Async reset mid-grant: rst_n low mid-cycle while gnt=0x10 -> gnt=0, sel=000, out_valid=0 without waiting for a clock edge. After release, the first grant again starts searching from index 0.
- Lock (MUX8_ARB_LOCK_EN): req=0x03, lock=1 on 3 accepts -> gnt stays 0x01 for all 3. lock=0 on the 4th accept -> gnt=0x02.
